// File: rtl/conv_operand_feeder_if.sv
// rtl/conv_operand_feeder_if.sv - RAM read ports and operand output stream of the conv operand feeder
interface conv_operand_feeder_if #(
    parameter int BITWIDTH        = 8,
    parameter int FMAP_ADDR_WIDTH = 12,
    parameter int W_ADDR_WIDTH    = 7
);
    logic        [FMAP_ADDR_WIDTH-1:0] fmap_addr;
    logic signed [BITWIDTH-1:0]        fmap_rdata;
    logic        [W_ADDR_WIDTH-1:0]    w_addr;
    logic signed [BITWIDTH-1:0]        w_rdata;
    logic                              out_valid;
    logic                              out_ready;
    logic signed [BITWIDTH-1:0]        weight;
    logic signed [BITWIDTH-1:0]        data;
    logic signed [2*BITWIDTH-1:0]      bias;
    logic                              win_first;
    logic                              win_last;

    modport master (
        output fmap_addr, w_addr, out_valid, weight, data, bias, win_first, win_last,
        input  fmap_rdata, w_rdata, out_ready
    );

    modport slave (
        input  fmap_addr, w_addr, out_valid, weight, data, bias, win_first, win_last,
        output fmap_rdata, w_rdata, out_ready
    );
endinterface

// File: rtl/conv_operand_feeder.sv
// rtl/conv_operand_feeder.sv - sequences fmap/weight RAM reads and streams tagged (weight, data) pairs
// through a 2-entry FIFO to the 5x5 convolution MAC.
module conv_operand_feeder #(
    parameter int BITWIDTH        = 8,
    parameter int FILTER_WIDTH    = 5,
    parameter int FILTER_HEIGHT   = 5,
    parameter int FILTER_CHANNEL  = 3,
    parameter int IN_WIDTH        = 32,
    parameter int IN_HEIGHT       = 32,
    parameter int FMAP_ADDR_WIDTH = 12,
    parameter int W_ADDR_WIDTH    = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [2*BITWIDTH-1:0] bias_in,
    output logic                         busy,
    output logic                         done,
    conv_operand_feeder_if.master        bus
);
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OUT_W = IN_WIDTH - FILTER_WIDTH + 1;
    localparam int OUT_H = IN_HEIGHT - FILTER_HEIGHT + 1;
    localparam int KCW   = cnt_width(FILTER_WIDTH);
    localparam int KRW   = cnt_width(FILTER_HEIGHT);
    localparam int CHW   = cnt_width(FILTER_CHANNEL);
    localparam int OCW   = cnt_width(OUT_W);
    localparam int ORW   = cnt_width(OUT_H);
    localparam int FAW   = FMAP_ADDR_WIDTH;
    localparam int WAW   = W_ADDR_WIDTH;

    localparam logic [KCW-1:0] KC_MAX = KCW'(FILTER_WIDTH - 1);
    localparam logic [KRW-1:0] KR_MAX = KRW'(FILTER_HEIGHT - 1);
    localparam logic [CHW-1:0] CH_MAX = CHW'(FILTER_CHANNEL - 1);
    localparam logic [OCW-1:0] OC_MAX = OCW'(OUT_W - 1);
    localparam logic [ORW-1:0] OR_MAX = ORW'(OUT_H - 1);

    // Constant address deltas applied when an inner loop wraps into the next outer one.
    localparam logic [FAW-1:0] STEP_KR  = FAW'(IN_WIDTH - FILTER_WIDTH + 1);
    localparam logic [FAW-1:0] STEP_CH  = FAW'(IN_HEIGHT * IN_WIDTH - (FILTER_HEIGHT - 1) * IN_WIDTH
                                              - (FILTER_WIDTH - 1));
    localparam logic [FAW-1:0] STEP_ROW = FAW'(FILTER_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [BITWIDTH-1:0] weight;
        logic [BITWIDTH-1:0] data;
        logic                first;
        logic                last;
    } entry_t;

    state_t                 state_q, state_d;
    logic [KCW-1:0]         kc_q, kc_d;
    logic [KRW-1:0]         kr_q, kr_d;
    logic [CHW-1:0]         ch_q, ch_d;
    logic [OCW-1:0]         ocol_q, ocol_d;
    logic [ORW-1:0]         orow_q, orow_d;
    logic [FAW-1:0]         fmap_addr_q, fmap_addr_d;
    logic [FAW-1:0]         win_base_q, win_base_d;
    logic [WAW-1:0]         w_addr_q, w_addr_d;
    logic                   inflight_q, inflight_d;
    logic                   sh_first_q, sh_first_d;
    logic                   sh_last_q, sh_last_d;
    logic [1:0]             cnt_q, cnt_d;
    entry_t                 head_q, head_d;
    entry_t                 tail_q, tail_d;
    logic [2*BITWIDTH-1:0]  bias_q, bias_d;

    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [2:0]             occ;
    logic                   kc_end, kr_end, ch_end, oc_end, or_end;
    logic                   cur_first, cur_last;
    entry_t                 push_entry;

    always_comb begin
        kc_end    = (kc_q == KC_MAX);
        kr_end    = (kr_q == KR_MAX);
        ch_end    = (ch_q == CH_MAX);
        oc_end    = (ocol_q == OC_MAX);
        or_end    = (orow_q == OR_MAX);
        cur_first = (kc_q == '0) && (kr_q == '0) && (ch_q == '0);
        cur_last  = kc_end && kr_end && ch_end;

        pop  = (cnt_q != 2'd0) && bus.out_ready;
        push = inflight_q;
        // Slots already committed: stored entries plus the read returning now, minus this cycle's pop.
        occ   = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
        issue = (state_q == S_ISSUE) && (occ < 3'd2);

        push_entry.weight = bus.w_rdata;
        push_entry.data   = bus.fmap_rdata;
        push_entry.first  = sh_first_q;
        push_entry.last   = sh_last_q;
    end

    always_comb begin
        state_d     = state_q;
        kc_d        = kc_q;
        kr_d        = kr_q;
        ch_d        = ch_q;
        ocol_d      = ocol_q;
        orow_d      = orow_q;
        fmap_addr_d = fmap_addr_q;
        win_base_d  = win_base_q;
        w_addr_d    = w_addr_q;
        bias_d      = bias_q;
        inflight_d  = issue;
        sh_first_d  = issue ? cur_first : sh_first_q;
        sh_last_d   = issue ? cur_last : sh_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ISSUE;
                    bias_d      = bias_in;
                    kc_d        = '0;
                    kr_d        = '0;
                    ch_d        = '0;
                    ocol_d      = '0;
                    orow_d      = '0;
                    fmap_addr_d = '0;
                    win_base_d  = '0;
                    w_addr_d    = '0;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    if (!kc_end) begin
                        kc_d        = kc_q + KCW'(1);
                        fmap_addr_d = fmap_addr_q + FAW'(1);
                        w_addr_d    = w_addr_q + WAW'(1);
                    end else if (!kr_end) begin
                        kc_d        = '0;
                        kr_d        = kr_q + KRW'(1);
                        fmap_addr_d = fmap_addr_q + STEP_KR;
                        w_addr_d    = w_addr_q + WAW'(1);
                    end else if (!ch_end) begin
                        kc_d        = '0;
                        kr_d        = '0;
                        ch_d        = ch_q + CHW'(1);
                        fmap_addr_d = fmap_addr_q + STEP_CH;
                        w_addr_d    = w_addr_q + WAW'(1);
                    end else if (!oc_end) begin
                        kc_d        = '0;
                        kr_d        = '0;
                        ch_d        = '0;
                        ocol_d      = ocol_q + OCW'(1);
                        win_base_d  = win_base_q + FAW'(1);
                        fmap_addr_d = win_base_q + FAW'(1);
                        w_addr_d    = '0;
                    end else if (!or_end) begin
                        kc_d        = '0;
                        kr_d        = '0;
                        ch_d        = '0;
                        ocol_d      = '0;
                        orow_d      = orow_q + ORW'(1);
                        win_base_d  = win_base_q + STEP_ROW;
                        fmap_addr_d = win_base_q + STEP_ROW;
                        w_addr_d    = '0;
                    end else begin
                        // Final pair issued; addresses stay on the last location.
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && (cnt_q == 2'd1) && !inflight_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Head register is the visible output; the tail only fills when the head is occupied.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = push_entry;
                end else begin
                    tail_d = push_entry;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                end
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = push_entry;
                end else begin
                    head_d = tail_q;
                    tail_d = push_entry;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            kc_q        <= '0;
            kr_q        <= '0;
            ch_q        <= '0;
            ocol_q      <= '0;
            orow_q      <= '0;
            fmap_addr_q <= '0;
            win_base_q  <= '0;
            w_addr_q    <= '0;
            inflight_q  <= 1'b0;
            sh_first_q  <= 1'b0;
            sh_last_q   <= 1'b0;
            cnt_q       <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            bias_q      <= '0;
        end else begin
            state_q     <= state_d;
            kc_q        <= kc_d;
            kr_q        <= kr_d;
            ch_q        <= ch_d;
            ocol_q      <= ocol_d;
            orow_q      <= orow_d;
            fmap_addr_q <= fmap_addr_d;
            win_base_q  <= win_base_d;
            w_addr_q    <= w_addr_d;
            inflight_q  <= inflight_d;
            sh_first_q  <= sh_first_d;
            sh_last_q   <= sh_last_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            bias_q      <= bias_d;
        end
    end

    assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign bus.fmap_addr = fmap_addr_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.weight    = head_q.weight;
    assign bus.data      = head_q.data;
    assign bus.win_first = head_q.first;
    assign bus.win_last  = head_q.last;
    assign bus.bias      = bias_q;

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (cnt_q == 2'd2)));
endmodule

// File: tb/tb_conv_operand_feeder.sv
// tb/tb_conv_operand_feeder.sv - directed bench for conv_operand_feeder (6x6 map, 2 channels, 5x5 kernel)
module tb_conv_operand_feeder;
    localparam int BW    = 8;
    localparam int FW    = 5;
    localparam int FH    = 5;
    localparam int FC    = 2;
    localparam int IW    = 6;
    localparam int IH    = 6;
    localparam int FAW   = 7;
    localparam int WAW   = 6;
    localparam int OW    = IW - FW + 1;
    localparam int OH    = IH - FH + 1;
    localparam int WIN   = FC * FH * FW;
    localparam int NPAIR = OH * OW * WIN;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic signed [15:0]  bias_in;
    logic                busy;
    logic                done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] fmem [128];
    logic [7:0] wmem [64];
    logic [7:0] exp_d [NPAIR];
    logic [7:0] exp_w [NPAIR];
    bit         exp_f [NPAIR];
    bit         exp_l [NPAIR];

    logic [7:0] cap_d [$];
    logic [7:0] cap_w [$];
    bit         cap_f [$];
    bit         cap_l [$];
    int         done_cnt;
    int         done_cyc;
    int         first_valid_cyc;
    int         stall_err;
    int         bias_err;
    logic [15:0] bias_exp;
    bit          stall_pending;
    logic [17:0] prev_head;

    conv_operand_feeder_if #(.BITWIDTH(BW), .FMAP_ADDR_WIDTH(FAW), .W_ADDR_WIDTH(WAW)) bif ();

    conv_operand_feeder #(
        .BITWIDTH(BW), .FILTER_WIDTH(FW), .FILTER_HEIGHT(FH), .FILTER_CHANNEL(FC),
        .IN_WIDTH(IW), .IN_HEIGHT(IH), .FMAP_ADDR_WIDTH(FAW), .W_ADDR_WIDTH(WAW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bias_in(bias_in),
        .busy(busy), .done(done), .bus(bif)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        bif.fmap_rdata <= fmem[bif.fmap_addr];
        bif.w_rdata    <= wmem[bif.w_addr];
    end

    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        cyc++;
        if (rnd) bif.out_ready = ($urandom_range(0, 9) < 3);
        if (reset) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending && (!bif.out_valid ||
                {bif.weight, bif.data, bif.win_first, bif.win_last} !== prev_head)) stall_err++;
            stall_pending = bif.out_valid && !bif.out_ready;
            prev_head = {bif.weight, bif.data, bif.win_first, bif.win_last};
            if (bif.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bif.out_valid && bif.out_ready) begin
                cap_d.push_back(bif.data);
                cap_w.push_back(bif.weight);
                cap_f.push_back(bif.win_first);
                cap_l.push_back(bif.win_last);
                if (bif.bias !== bias_exp) bias_err++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic do_start(input logic [15:0] b, output int t0);
        cap_d.delete(); cap_w.delete(); cap_f.delete(); cap_l.delete();
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        stall_err = 0; bias_err = 0; stall_pending = 1'b0;
        bias_exp = b;
        bias_in  = b;
        start    = 1'b1;
        t0       = cyc;
        step(1'b0);
        start    = 1'b0;
    endtask

    task automatic run_to_done(input bit rnd, input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) step(rnd);
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout got no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step(1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bif.out_valid); end
        checks++; if ({bif.fmap_addr, bif.w_addr} !== '0) begin errors++;
            $display("FAIL reset_addr got fmap %0d w %0d want 0 0", bif.fmap_addr, bif.w_addr); end
        checks++; if ({bif.weight, bif.data, bif.bias, bif.win_first, bif.win_last} !== '0) begin errors++;
            $display("FAIL reset_head got w %h d %h b %h f %b l %b want 0", bif.weight, bif.data, bif.bias, bif.win_first, bif.win_last); end
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        reset = 1'b0;
        repeat (2) step(1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_with_reset got busy %0b want 0", busy); end
    endtask

    task automatic test_stream();
        int t0;
        int bad;
        do_start(16'h1234, t0);
        checks++; if (bif.fmap_addr !== 7'd0 || bif.w_addr !== 6'd0 || busy !== 1'b1) begin errors++;
            $display("FAIL first_issue got fmap %0d w %0d busy %0b want 0 0 1", bif.fmap_addr, bif.w_addr, busy); end
        run_to_done(1'b0, 400);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %0b want 0", busy); end
        checks++; if (first_valid_cyc != t0 + 3) begin errors++;
            $display("FAIL first_valid_latency got %0d want %0d", first_valid_cyc - t0, 3); end
        checks++; if (done_cyc != t0 + NPAIR + 3) begin errors++;
            $display("FAIL done_cycle got %0d want %0d", done_cyc - t0, NPAIR + 3); end
        checks++; if (cap_d.size() != NPAIR) begin errors++;
            $display("FAIL stream_pops got %0d want %0d", cap_d.size(), NPAIR); end
        bad = 0;
        for (int i = 0; i < NPAIR && i < cap_d.size(); i++) begin
            checks++;
            if (cap_d[i] !== exp_d[i] || cap_w[i] !== exp_w[i] || cap_f[i] !== exp_f[i] || cap_l[i] !== exp_l[i]) begin
                errors++;
                if (bad < 5) $display("FAIL stream_pair[%0d] got d %0d w %0d f %0b l %0b want d %0d w %0d f %0b l %0b",
                    i, cap_d[i], cap_w[i], cap_f[i], cap_l[i], exp_d[i], exp_w[i], exp_f[i], exp_l[i]);
                bad++;
            end
        end
        checks++; if (bif.fmap_addr !== 7'd71 || bif.w_addr !== 6'd49) begin errors++;
            $display("FAIL last_addr got fmap %0d w %0d want 71 49", bif.fmap_addr, bif.w_addr); end
        repeat (4) step(1'b0);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_once got %0d want 1", done_cnt); end
        checks++; if (bias_err != 0) begin errors++; $display("FAIL stream_bias got %0d bad pops want 0", bias_err); end
    endtask

    task automatic test_backpressure();
        int t0;
        int bad;
        do_start(16'hFF80, t0);
        bias_in = 16'h0123;
        run_to_done(1'b1, 3000);
        bif.out_ready = 1'b1;
        checks++; if (cap_d.size() != NPAIR) begin errors++;
            $display("FAIL bp_pops got %0d want %0d", cap_d.size(), NPAIR); end
        bad = 0;
        for (int i = 0; i < NPAIR && i < cap_d.size(); i++) begin
            checks++;
            if (cap_d[i] !== exp_d[i] || cap_w[i] !== exp_w[i] || cap_f[i] !== exp_f[i] || cap_l[i] !== exp_l[i]) begin
                errors++;
                if (bad < 5) $display("FAIL bp_pair[%0d] got d %0d w %0d want d %0d w %0d", i, cap_d[i], cap_w[i], exp_d[i], exp_w[i]);
                bad++;
            end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_head_stable got %0d changes want 0", stall_err); end
        checks++; if (bias_err != 0 || bif.bias !== 16'hFF80) begin errors++;
            $display("FAIL bp_bias got %h (%0d bad pops) want ff80", bif.bias, bias_err); end
        repeat (3) step(1'b0);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_once got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        int t0;
        do_start(16'h0042, t0);
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            start = (cyc == t0 + 20) || (cyc == t0 + 50);
            if (start) bias_in = 16'h5555;
            step(1'b0);
        end
        start = 1'b0;
        checks++; if (cap_d.size() != NPAIR) begin errors++;
            $display("FAIL restart_pops got %0d want %0d", cap_d.size(), NPAIR); end
        checks++; if (done_cyc != t0 + NPAIR + 3) begin errors++;
            $display("FAIL restart_done_cycle got %0d want %0d", done_cyc - t0, NPAIR + 3); end
        checks++; if (bias_err != 0 || bif.bias !== 16'h0042) begin errors++;
            $display("FAIL restart_bias got %h want 0042", bif.bias); end
        repeat (3) step(1'b0);
        checks++; if (done_cnt != 1 || busy !== 1'b0) begin errors++;
            $display("FAIL restart_idle got done_cnt %0d busy %0b want 1 0", done_cnt, busy); end
    endtask

    task automatic test_reset_mid();
        int t0;
        do_start(16'h0007, t0);
        for (int k = 0; k < 300 && cap_d.size() < 40; k++) step(1'b0);
        checks++; if (cap_d.size() != 40) begin errors++;
            $display("FAIL midreset_pops got %0d want 40", cap_d.size()); end
        reset = 1'b1;
        step(1'b0);
        checks++; if (busy !== 1'b0 || bif.out_valid !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL midreset_state got busy %0b valid %0b done %0b want 0 0 0", busy, bif.out_valid, done); end
        reset = 1'b0;
        repeat (5) step(1'b0);
        checks++; if (done_cnt != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL midreset_no_done got done_cnt %0d busy %0b want 0 0", done_cnt, busy); end
        do_start(16'h0009, t0);
        checks++; if (bif.fmap_addr !== 7'd0 || bif.w_addr !== 6'd0) begin errors++;
            $display("FAIL midreset_restart_addr got fmap %0d w %0d want 0 0", bif.fmap_addr, bif.w_addr); end
        run_to_done(1'b0, 400);
        checks++; if (cap_d.size() != NPAIR || cap_d[0] !== 8'd0 || cap_f[0] !== 1'b1) begin errors++;
            $display("FAIL midreset_restart got %0d pops want %0d from window 0", cap_d.size(), NPAIR); end
        checks++; if (done_cyc != t0 + NPAIR + 3) begin errors++;
            $display("FAIL midreset_done_cycle got %0d want %0d", done_cyc - t0, NPAIR + 3); end
    endtask

    initial begin
        int k;
        for (int i = 0; i < 128; i++) fmem[i] = 8'(i);
        for (int i = 0; i < 64; i++) wmem[i] = 8'(i + 100);
        k = 0;
        for (int orow = 0; orow < OH; orow++)
            for (int ocol = 0; ocol < OW; ocol++)
                for (int ch = 0; ch < FC; ch++)
                    for (int kr = 0; kr < FH; kr++)
                        for (int kc = 0; kc < FW; kc++) begin
                            exp_d[k] = 8'(ch * IH * IW + (orow + kr) * IW + ocol + kc);
                            exp_w[k] = 8'(ch * FH * FW + kr * FW + kc + 100);
                            exp_f[k] = (ch == 0) && (kr == 0) && (kc == 0);
                            exp_l[k] = (ch == FC - 1) && (kr == FH - 1) && (kc == FW - 1);
                            k++;
                        end
        reset = 1'b1;
        start = 1'b0;
        bias_in = '0;
        bias_exp = '0;
        bif.out_ready = 1'b1;
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        stall_err = 0; bias_err = 0; stall_pending = 1'b0; prev_head = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_operand_feeder.md
Name: conv_operand_feeder

Overview:
- Producer side of the 5x5 convolution MAC: sequences feature-map and weight RAM reads and streams one signed (weight, data) pair per cycle.
- Tags each pair with window first/last flags so the downstream multiply-accumulate filter can clear and dump its accumulator.
- One start pulse convolves one full multi-channel input map, valid-only, stride 1, producing every output position in row-major order.
- A 2-entry output FIFO absorbs the 1-cycle RAM read latency and consumer back-pressure.

Parameters:
- BITWIDTH, 8, width of weight and data samples.
- FILTER_WIDTH, 5, kernel columns.
- FILTER_HEIGHT, 5, kernel rows.
- FILTER_CHANNEL, 3, input channels.
- IN_WIDTH, 32, feature-map columns.
- IN_HEIGHT, 32, feature-map rows.
- FMAP_ADDR_WIDTH, 12, feature-map RAM address width; must cover FILTER_CHANNEL*IN_HEIGHT*IN_WIDTH.
- W_ADDR_WIDTH, 7, weight RAM address width; must cover FILTER_CHANNEL*FILTER_HEIGHT*FILTER_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass; ignored while busy.
- bias_in  in  2*BITWIDTH  signed bias, captured on accepted start.
- fmap_addr  out  FMAP_ADDR_WIDTH  feature-map RAM read address (registered).
- fmap_rdata  in  BITWIDTH  signed; valid 1 cycle after address.
- w_addr  out  W_ADDR_WIDTH  weight RAM read address (registered).
- w_rdata  in  BITWIDTH  signed; valid 1 cycle after address.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head this cycle.
- weight  out  BITWIDTH  head weight.
- data  out  BITWIDTH  head data.
- bias  out  2*BITWIDTH  captured bias, held until next accepted start.
- win_first  out  1  head is the first pair of an output window.
- win_last  out  1  head is the last pair of an output window.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at pass end.

Behaviour:
- Reset: busy=0, done=0, out_valid=0, FIFO emptied, in-flight read discarded, all counters cleared. fmap_addr, w_addr, weight, data, bias, win_first, win_last all 0. Reset mid-pass aborts with no done pulse.
- Derived sizes: OUT_W = IN_WIDTH-FILTER_WIDTH+1, OUT_H = IN_HEIGHT-FILTER_HEIGHT+1. WIN = FILTER_CHANNEL*FILTER_HEIGHT*FILTER_WIDTH (75 at defaults). Total pairs = OUT_H*OUT_W*WIN (58800 at defaults).
- FSM states:
  - IDLE: on start goes to ISSUE; captures bias_in; zeroes counters.
  - ISSUE: generates addresses.
  - DRAIN: entered after the final address issue; waits for the last read to return and the FIFO to empty.
  - DONE: single cycle; pulses done, returns to IDLE.
- busy=1 in ISSUE and DRAIN. start asserted while busy has no effect. start coincident with reset is ignored.
- Loop order, innermost first: kc, kr, ch, ocol, orow.
  - fmap_addr = ch*IN_HEIGHT*IN_WIDTH + (orow+kr)*IN_WIDTH + (ocol+kc).
  - w_addr = ch*FILTER_HEIGHT*FILTER_WIDTH + kr*FILTER_WIDTH + kc.
  - Implement with incremental counters, no multipliers in the address path.
- Issue rule: an address pair issues in a cycle iff state==ISSUE and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready. Otherwise counters and addresses hold.
- Flags travel with each read through a 1-cycle shadow register. win_first is set when kc=kr=ch=0; win_last when kc=FW-1, kr=FH-1, ch=FILTER_CHANNEL-1.
- Returned rdata plus flags is pushed into the FIFO exactly one cycle after issue. The FIFO never overflows by construction; a push when full is an assertion error.
- Latency: with start accepted in cycle T and out_ready=1, first address is driven in T+1, rdata returns in T+2, and out_valid=1 in T+3. Sustained throughput is 1 pair/cycle.
- Back-pressure: while out_valid=1 and out_ready=0, head outputs hold stable. Issue stops once two entries are committed. Simultaneous push and pop keeps count unchanged.
- done pulses in the cycle after the final pair (win_last of the last window) is popped. busy drops in that same cycle.
- No arithmetic on data; samples pass through bit-exact.

Test Plan:
- Params IN 6x6, CH 1, filter 5x5 (OUT 2x2, 100 pairs). Set fmap[i]=i, w[i]=i+100, out_ready=1, start at cycle 10 → out_valid first at cycle 13. Window 0 data = 0,1,2,3,4,6,…,28. Window 1 starts at data 1. Flags: first on pairs 0/25/50/75, last on 24/49/74/99. done at cycle 113.
- Default params, out_ready=1 → exactly 58800 pops. Last pair has fmap_addr 3071 and w_addr 74. done pulses once.
- Random out_ready at 30% → same pop sequence as the previous run. No FIFO overflow. Head stable whenever out_ready=0.
- start re-pulsed at cycles 20 and 50 during a pass → ignored; total pops unchanged; bias unchanged.
- reset asserted mid-pass at pop 40 → next cycle busy=0, out_valid=0, no done. A new start restarts from window 0 with fmap_addr=0.
- bias_in=16'hFF80 on start, changed afterwards → bias output stays 16'hFF80 for the whole pass.
